// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared decode constants for the ColourGenie CPU bus controller:
// memory region bounds, I/O port numbers and the region classifier.
package cg_bus_pkg;

    localparam logic [15:0] ROM_BASE  = 16'h0000;
    localparam logic [15:0] ROM_LIMIT = 16'h3FFF;
    localparam logic [15:0] RAM_BASE  = 16'h4000;
    localparam logic [15:0] RAM_LIMIT = 16'hBFFF;
    localparam logic [15:0] CRAM_BASE  = 16'hF000;
    localparam logic [15:0] CRAM_LIMIT = 16'hF3FF;
    localparam logic [15:0] KBD_BASE  = 16'hF800;
    localparam logic [15:0] KBD_LIMIT = 16'hFBFF;

    localparam logic [7:0] PORT_PSG_A = 8'hF8;
    localparam logic [7:0] PORT_PSG_D = 8'hF9;
    localparam logic [7:0] PORT_SYS   = 8'hFF;

    typedef enum logic [2:0] {
        R_ROM,
        R_RAM,
        R_CRAM,
        R_KBD,
        R_NONE
    } region_e;

    function automatic region_e region_of(input logic [15:0] addr);
        if (addr <= ROM_LIMIT)                              return R_ROM;
        else if (addr >= RAM_BASE  && addr <= RAM_LIMIT)    return R_RAM;
        else if (addr >= CRAM_BASE && addr <= CRAM_LIMIT)   return R_CRAM;
        else if (addr >= KBD_BASE  && addr <= KBD_LIMIT)    return R_KBD;
        else                                                return R_NONE;
    endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus between the Z80 wrapper (master) and the bus controller (slave).
interface cpu_bus_ctrl_if;
    logic        rfsh;
    logic        mreq;
    logic        iorq;
    logic        wr;
    logic        rd;
    logic [15:0] a;
    logic [7:0]  q;
    logic [7:0]  d;

    modport master (output rfsh, mreq, iorq, wr, rd, a, q, input d);
    modport slave  (input rfsh, mreq, iorq, wr, rd, a, q, output d);
endinterface

// File: rtl/cpu_bus_ctrl_wr_oneshot.sv
// One write pulse per CPU write cycle; re-armed only once wr has been seen high.
module wr_oneshot (
    input  logic clock,
    input  logic reset,
    input  logic i_qual,
    input  logic i_wr_n,
    output logic o_fire,
    output logic o_pulse
);
    logic r_armed;
    logic r_rst_hold;
    logic r_pulse;

    // r_rst_hold blocks a write that was already in progress across reset
    assign o_fire  = i_qual && r_armed && !r_rst_hold;
    assign o_pulse = r_pulse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_armed    <= 1'b1;
            r_rst_hold <= 1'b1;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= o_fire;
            if (i_wr_n) begin
                r_armed    <= 1'b1;
                r_rst_hold <= 1'b0;
            end else if (o_fire) begin
                r_armed <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cpu_bus_ctrl.sv
// ColourGenie address decoder / bus controller: memory and I/O decode,
// single-cycle write strobes, system port latch and registered read data.
module cpu_bus_ctrl
    import cg_bus_pkg::*;
#(
    parameter int          RAM_BITS = 15,
    parameter logic [7:0]  UNMAPPED = 8'hFF
) (
    input  logic                clock,
    input  logic                reset,
    cpu_bus_ctrl_if.slave       cpu,
    output logic [13:0]         rom_a,
    input  logic [7:0]          rom_d,
    output logic [RAM_BITS-1:0] ram_a,
    output logic                ram_we,
    output logic [7:0]          ram_d,
    input  logic [7:0]          ram_q,
    output logic [9:0]          cram_a,
    output logic                cram_we,
    input  logic [3:0]          cram_q,
    output logic [7:0]          kbd_row,
    input  logic [7:0]          kbd_col,
    output logic [7:0]          port_ff,
    input  logic                cas_in,
    output logic                psg_addr_we,
    output logic                psg_data_we,
    output logic                psg_data_rd,
    input  logic [7:0]          psg_q
);
    region_e    w_region;
    logic       w_io_cyc, w_mem_cyc;
    logic       w_mem_rd, w_mem_wr, w_io_rd, w_io_wr;
    logic [7:0] w_port;
    logic [7:0] w_rd_data;
    logic       w_sys_fire, w_sys_pulse, w_ram_fire, w_cram_fire, w_psga_fire, w_psgd_fire;
    logic [7:0] r_port_ff;
    logic [7:0] r_d;

    assign w_region  = region_of(cpu.a);
    assign w_port    = cpu.a[7:0];
    // I/O wins when mreq and iorq are both low
    assign w_io_cyc  = cpu.rfsh && !cpu.iorq;
    assign w_mem_cyc = cpu.rfsh && !cpu.mreq && cpu.iorq;
    assign w_mem_rd  = w_mem_cyc && !cpu.rd;
    assign w_mem_wr  = w_mem_cyc && !cpu.wr;
    assign w_io_rd   = w_io_cyc && !cpu.rd;
    assign w_io_wr   = w_io_cyc && !cpu.wr;

    assign rom_a   = cpu.a[13:0];
    assign ram_a   = RAM_BITS'(cpu.a - RAM_BASE);
    assign ram_d   = cpu.q;
    assign cram_a  = cpu.a[9:0];
    assign kbd_row = cpu.a[7:0];
    assign port_ff = r_port_ff;
    assign cpu.d   = r_d;
    assign psg_data_rd = reset && w_io_rd && (w_port == PORT_PSG_D);

    wr_oneshot u_ram_os  (.clock, .reset, .i_qual(w_mem_wr && w_region == R_RAM),
                          .i_wr_n(cpu.wr), .o_fire(w_ram_fire),  .o_pulse(ram_we));
    wr_oneshot u_cram_os (.clock, .reset, .i_qual(w_mem_wr && w_region == R_CRAM),
                          .i_wr_n(cpu.wr), .o_fire(w_cram_fire), .o_pulse(cram_we));
    wr_oneshot u_psga_os (.clock, .reset, .i_qual(w_io_wr && w_port == PORT_PSG_A),
                          .i_wr_n(cpu.wr), .o_fire(w_psga_fire), .o_pulse(psg_addr_we));
    wr_oneshot u_psgd_os (.clock, .reset, .i_qual(w_io_wr && w_port == PORT_PSG_D),
                          .i_wr_n(cpu.wr), .o_fire(w_psgd_fire), .o_pulse(psg_data_we));
    wr_oneshot u_sys_os  (.clock, .reset, .i_qual(w_io_wr && w_port == PORT_SYS),
                          .i_wr_n(cpu.wr), .o_fire(w_sys_fire),  .o_pulse(w_sys_pulse));

    always_comb begin
        w_rd_data = UNMAPPED;
        if (w_io_rd) begin
            case (w_port)
                PORT_PSG_D: w_rd_data = psg_q;
                PORT_SYS:   w_rd_data = {r_port_ff[7:1], cas_in};
                default:    w_rd_data = UNMAPPED;
            endcase
        end else if (w_mem_rd) begin
            case (w_region)
                R_ROM:   w_rd_data = rom_d;
                R_RAM:   w_rd_data = ram_q;
                R_CRAM:  w_rd_data = {4'hF, cram_q};
                R_KBD:   w_rd_data = kbd_col;
                default: w_rd_data = UNMAPPED;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_d       <= 8'hFF;
            r_port_ff <= 8'h00;
        end else begin
            if (w_io_rd || w_mem_rd) r_d <= w_rd_data;
            if (w_sys_fire)          r_port_ff <= cpu.q;
        end
    end
endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Address decoder and bus controller directly downstream of the Z80 CPU wrapper in the ColourGenie core. It consumes the CPU's active-low strobes, address and write data, and produces single-cycle write enables, chip selects and a registered read-data bus back to the CPU. It also owns the system port latch at I/O 0xFF and the AY-3-8910 port strobes at 0xF8/0xF9. Refresh cycles are ignored.

## Interface
Parameters:
- RAM_BITS, 15, RAM address width; the RAM window is 0x4000–0xBFFF, 32 KB.
- UNMAPPED, 8'hFF, value returned for reads of unmapped memory or I/O.

Ports:
- clock  in  1  system clock. Single clock domain.
- reset  in  1  asynchronous, active-low reset.
- rfsh, mreq, iorq, wr, rd  in  1 each  active-low CPU strobes.
- a  in  16  CPU address.
- q  in  8  CPU write data.
- d  out  8  registered read data to the CPU.
- rom_a  out  14  ROM address, a[13:0].
- rom_d  in  8  ROM data.
- ram_a  out  RAM_BITS  equals a − 0x4000.
- ram_we  out  1  one-clock write pulse.
- ram_d  out  8  RAM write data, equals q.
- ram_q  in  8  RAM read data.
- cram_a  out  10  colour RAM address, a[9:0].
- cram_we  out  1  one-clock write pulse.
- cram_q  in  4  colour RAM nibble.
- kbd_row  out  8  keyboard row select, a[7:0].
- kbd_col  in  8  keyboard column data, active-high keys.
- port_ff  out  8  system latch: cassette out, CSS, mode bits.
- cas_in  in  1  cassette input bit.
- psg_addr_we, psg_data_we  out  1 each  one-clock pulses.
- psg_data_rd  out  1  level while an F9 read is active.
- psg_q  in  8  PSG read data.

## Operation
- Cycle qualifiers:
  - Memory read: mreq=0, rd=0, rfsh=1.
  - Memory write: mreq=0, wr=0, rfsh=1.
  - I/O read/write: iorq=0 with rd=0 or wr=0 respectively.
  - Cycles with rfsh=0 are never decoded. No strobes are issued and d holds its value.
- Memory map:
  - ROM 0x0000–0x3FFF. Writes are ignored.
  - RAM 0x4000–0xBFFF.
  - Colour RAM 0xF000–0xF3FF.
  - Keyboard 0xF800–0xFBFF, read-only.
  - Everything else is unmapped: reads return UNMAPPED, writes are dropped.
- I/O map uses a[7:0] only:
  - 0xF8 write → psg_addr_we.
  - 0xF9 write → psg_data_we; 0xF9 read → psg_q.
  - 0xFF write → port_ff ← q; 0xFF read → {port_ff[7:1], cas_in}.
  - Other ports read UNMAPPED; writes to them are dropped.
- Write strobes (ram_we, cram_we, psg_*_we, port_ff load):
  - Each fires exactly once per CPU write cycle, on the first clock its qualifier is seen true.
  - An armed flag re-arms only after wr returns high.
  - A write held low for N clocks therefore yields one pulse.
- Keyboard read returns the OR of kbd_col over the rows selected by a[7:0]. The external matrix performs the OR; this block passes kbd_col through.
- Colour RAM read returns {4'hF, cram_q}.

## Timing
- Reset values:
  - d = 8'hFF, port_ff = 8'h00.
  - All *_we = 0, psg_data_rd = 0, write-armed flags = armed.
- Read data: d is registered every clock from the decoded source, giving 1-clock latency from a stable address and strobe. CPU read cycles span ≥2 clocks, so d is valid when the CPU samples DI.
- Address outputs (rom_a, ram_a, cram_a, kbd_row) and ram_d are combinational, with zero latency.
- Write pulse timing: high during the clock after the qualifying edge, exactly 1 clock wide.
- port_ff updates on that same edge.
- A back-to-back write cycle gets its own pulse provided wr went high for ≥1 clock in between.
- Asserting reset mid-write clears the pulse immediately. After release, the in-progress write is not reissued if wr is still low; the flag stays disarmed until wr rises.
- If mreq and iorq are both low, I/O takes precedence and no memory strobe is issued.

## Structure
- Package cg_bus_pkg holds region base/limit constants, I/O port numbers (PORT_PSG_A=8'hF8, PORT_PSG_D=8'hF9, PORT_SYS=8'hFF) and the region enum {R_ROM, R_RAM, R_CRAM, R_KBD, R_NONE}.
- One sub-module, wr_oneshot: a qualifier input produces a one-clock pulse, re-armed by wr high. It is instantiated once per write target.

## Test plan
- Reset: with reset held low, d=8'hFF and port_ff=0. After release with strobes idle, all *_we stay 0 for 10 clocks.
- Memory write: a=0x4123, q=0x5A, mreq=wr=0 for 6 clocks → ram_we high exactly 1 clock, ram_a=0x0123, ram_d=0x5A. Repeating at a=0x2000 (ROM) produces no pulse.
- Refresh: a refresh cycle with rfsh=0, mreq=0, a=0x4000 → no ram_we, d unchanged. A following read at 0x0005 with rom_d=0xC3 → d=0xC3 one clock later.
- I/O port FF: OUT (0xFF),0xA6 then IN 0xFF with cas_in=1 → port_ff=0xA6, d=0xA7. IN 0x10 → d=0xFF.
- PSG: write 0xF8 then 0xF9 → one psg_addr_we pulse, then one psg_data_we pulse. A read of F9 with psg_q=0x3C → psg_data_rd high and d=0x3C.
- Reset mid-write: reset low during the 2nd clock of a colour-RAM write at 0xF010 with wr held low through release → exactly one cram_we before reset and none after, until wr toggles high then low.
